// File: rtl/frb_frame_integrator.sv
// frb_frame_integrator: sums each N_CHANNELS-sample frame and flags threshold crossings with frame holdoff
module frb_frame_integrator #(
  parameter int N_CHANNELS = 64,
  parameter int DIN_WIDTH  = 32,
  parameter int SUM_WIDTH  = DIN_WIDTH + $clog2(N_CHANNELS),
  parameter int FCNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_valid,
  input  logic                  din_sof,
  input  logic                  din_eof,
  input  logic [SUM_WIDTH-1:0]  threshold,
  input  logic [15:0]           holdoff,
  output logic [SUM_WIDTH-1:0]  sum,
  output logic                  sum_valid,
  output logic [FCNT_WIDTH-1:0] frame_cnt,
  output logic                  detect,
  output logic                  frame_err
);
  localparam int CW = $clog2(N_CHANNELS) + 1;
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_nx;
  logic [SUM_WIDTH-1:0] acc, acc_nx, thr_lat, thr_nx, add;
  logic [CW-1:0] cnt, cnt_nx;
  logic [FCNT_WIDTH-1:0] good_cnt;
  logic [15:0] hold_cnt;
  logic take, last, good, err, fire;
  assign take = ce & din_valid;
  assign add  = acc + SUM_WIDTH'(din);
  assign last = (cnt + CW'(1)) == CW'(N_CHANNELS);
  assign fire = good & (add > thr_lat) & (hold_cnt == 16'd0);
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    thr_nx   = thr_lat;
    good     = 1'b0;
    err      = 1'b0;
    if (take) begin
      if (state == IDLE) begin
        if (din_sof && din_eof) err = 1'b1;
        else if (din_sof) begin
          state_nx = ACCUM;
          acc_nx   = SUM_WIDTH'(din);
          cnt_nx   = CW'(1);
          thr_nx   = threshold;
        end
      end else if (din_sof) begin
        // restart discards the open frame; a one-sample frame can never be good
        err = 1'b1;
        if (din_eof) state_nx = IDLE;
        else begin
          acc_nx = SUM_WIDTH'(din);
          cnt_nx = CW'(1);
          thr_nx = threshold;
        end
      end else begin
        acc_nx = add;
        cnt_nx = cnt + CW'(1);
        if (din_eof || last) begin
          state_nx = IDLE;
          good     = din_eof & last;
          err      = ~(din_eof & last);
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      thr_lat   <= '0;
      sum       <= '0;
      sum_valid <= 1'b0;
      frame_cnt <= '0;
      good_cnt  <= '0;
      detect    <= 1'b0;
      frame_err <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      thr_lat   <= thr_nx;
      sum_valid <= good;
      detect    <= fire;
      frame_err <= err;
      if (good) begin
        sum       <= add;
        frame_cnt <= good_cnt;
        good_cnt  <= good_cnt + FCNT_WIDTH'(1);
        hold_cnt  <= fire ? holdoff : (hold_cnt != 16'd0) ? hold_cnt - 16'd1 : hold_cnt;
      end
    end
  end
endmodule
